// File: rtl/logic_unit_seq.sv
// Sequenced bitwise logic unit (AND/OR/XOR/NOR), W bits per cycle over an N-bit operand pair.
// Latency: out_valid N/W cycles after the request handshake; no overlap between operations.
// Backpressure: in_ready low while busy; result held in DONE until out_ready. Optional zero flag: LOGIC_UNIT_SEQ_ZERO_FLAG_EN.
module logic_unit_seq #(
    parameter int N = 64,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         busy
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
    ,
    output logic         zero
`endif
);

    localparam int NS = N / W;
    localparam int CW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, b_q, result_q;
    logic [1:0]    op_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  a_sl, b_sl, slice;
    logic          zero_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == LAST) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Constant-index mux keeps the slice select free of variable part-selects.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < NS; k++) begin
            if (cnt_q == CW'(k)) begin
                a_sl = a_q[k*W +: W];
                b_sl = b_q[k*W +: W];
            end
        end
    end

    always_comb begin
        case (op_q)
            2'b00:   slice = a_sl & b_sl;
            2'b01:   slice = a_sl | b_sl;
            2'b10:   slice = a_sl ^ b_sl;
            default: slice = ~(a_sl | b_sl);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 2'b00;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        op_q   <= op;
                        cnt_q  <= '0;
                        zero_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NS; k++) begin
                        if (cnt_q == CW'(k)) result_q[k*W +: W] <= slice;
                    end
                    if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
                    zero_q <= zero_q & (slice == '0);
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
    assign zero = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed, table-driven bench for logic_unit_seq (N=64, W=16).
module tb_logic_unit_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
    logic        zero;
`endif

    int errors = 0;
    int checks = 0;

    logic_unit_seq #(.N(64), .W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
        ,
        .zero      (zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        int cycles;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        chk({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        op       = v.op;
        a        = v.a;
        b        = v.b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble the inputs while the operation is in flight.
        op = 2'($urandom);
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        chk({tag, " busy in run"}, 64'(busy), 64'd1);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        chk({tag, " latency"}, 64'(cycles), 64'd4);
        chk({tag, " result"}, result, v.exp);
        chk({tag, " in_ready done"}, 64'(in_ready), 64'd0);
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
        chk({tag, " zero"}, 64'(zero), 64'(v.exp == 64'd0));
`endif
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold result"}, result, v.exp);
            chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, " valid dropped"}, 64'(out_valid), 64'd0);
        chk({tag, " in_ready back"}, 64'(in_ready), 64'd1);
        chk({tag, " result kept"}, result, v.exp);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t post;
        logic saw_valid;

        vecs[0] = '{2'b00, 64'hFFFF_0000_F0F0_00FF, 64'h0F0F_FFFF_FF00_0F0F, 64'h0F0F_0000_F000_000F, 10};
        vecs[1] = '{2'b00, 64'h000C, 64'h000A, 64'h0008, 0};
        vecs[2] = '{2'b01, 64'h000C, 64'h000A, 64'h000E, 0};
        vecs[3] = '{2'b10, 64'h000C, 64'h000A, 64'h0006, 0};
        vecs[4] = '{2'b11, 64'h000C, 64'h000A, 64'hFFFF_FFFF_FFFF_FFF1, 0};
        vecs[5] = '{2'b00, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'h0, 0};
        vecs[6] = '{2'b01, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        post    = '{2'b10, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 64'hEDCB_5678_6543_DEF0, 0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset result", result, 64'd0);
`ifdef LOGIC_UNIT_SEQ_ZERO_FLAG_EN
        chk("reset zero", 64'(zero), 64'd0);
`endif

        // out_ready while nothing is pending must not disturb IDLE.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("idle out_ready valid", 64'(out_valid), 64'd0);
        chk("idle out_ready busy", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++) run_op(vecs[i], i);

        // Reset two cycles into RUN.
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; a = 64'hFFFF_FFFF_FFFF_FFFF; b = '0;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("midrun valid", 64'(out_valid), 64'd0);
        chk("midrun busy", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst result", result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("midrst no valid", 64'(saw_valid), 64'd0);
        chk("midrst idle", 64'(in_ready), 64'd1);

        run_op(post, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
